// File: rtl/codec_adc_receiver.sv
// I2S ADC receiver: resynchronizes codec BCLK/ADCLRCK/ADCDAT, deserializes
// left/right words into stereo frames and queues them in a small FIFO.
module codec_adc_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEVEL_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   aud_bclk,
  input  logic                   aud_adclrck,
  input  logic                   aud_adcdat,
  output logic [DATA_WIDTH-1:0]  out_left,
  output logic [DATA_WIDTH-1:0]  out_right,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEVEL_WIDTH-1:0] fifo_level,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic [15:0]            frame_count
);
  localparam int PW = LEVEL_WIDTH - 1;
  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam int FW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} rx_state_t;

  rx_state_t             state, state_nxt;
  logic [1:0]            bclk_sync, lrck_sync, dat_sync;
  logic                  bclk_prev, lr_prev, left_ok, push_req;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-2:0] shift;
  logic [DATA_WIDTH-1:0] shift_nxt, left_hold;
  logic [FW-1:0]         push_frame, head, head_nxt;
  logic                  bclk_rise, lr_cur, boundary, capture, word_done;

  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign lr_cur    = lrck_sync[1];
  assign boundary  = bclk_rise & (lr_cur != lr_prev);
  assign shift_nxt = {shift, dat_sync[1]};
  // bit_cnt is 1 on the delay-bit rise; data occupies counts 1..DATA_WIDTH
  assign capture   = bclk_rise & ~boundary & (bit_cnt != '0) &
                     (bit_cnt <= CW'(DATA_WIDTH));
  assign word_done = capture & (bit_cnt == CW'(DATA_WIDTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], aud_bclk};
      lrck_sync <= {lrck_sync[0], aud_adclrck};
      dat_sync  <= {dat_sync[0], aud_adcdat};
      bclk_prev <= bclk_sync[1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) state_nxt = HUNT;
    else if (boundary) begin
      case (state)
        HUNT:    state_nxt = lr_cur ? HUNT : LEFT;
        LEFT:    state_nxt = lr_cur ? RIGHT : LEFT;
        RIGHT:   state_nxt = lr_cur ? RIGHT : LEFT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // lr_prev keeps tracking LRCK while disabled so re-enable resyncs on a real edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lr_prev    <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      left_hold  <= '0;
      left_ok    <= 1'b0;
      push_req   <= 1'b0;
      push_frame <= '0;
    end else begin
      push_req <= 1'b0;
      if (bclk_rise) lr_prev <= lr_cur;
      if (!enable) begin
        bit_cnt <= '0;
        left_ok <= 1'b0;
      end else if (boundary) begin
        bit_cnt <= (state_nxt == HUNT) ? '0 : CW'(1);
        if (!lr_cur) left_ok <= 1'b0;
      end else if (capture) begin
        shift   <= shift_nxt[DATA_WIDTH-2:0];
        bit_cnt <= bit_cnt + 1'b1;
        if (word_done && state == LEFT) begin
          left_hold <= shift_nxt;
          left_ok   <= 1'b1;
        end else if (word_done && state == RIGHT && left_ok) begin
          push_req   <= 1'b1;
          push_frame <= {left_hold, shift_nxt};
        end
      end
    end
  end

  logic [FW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr, rd_ptr_inc;
  logic                   pop, full, push_acc, drop;

  assign out_valid  = (fifo_level != '0);
  assign pop        = out_valid & out_ready;
  assign full       = (fifo_level == LEVEL_WIDTH'(FIFO_DEPTH));
  assign push_acc   = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign {out_left, out_right} = head;

  // head register tracks the entry that will be at the front next cycle
  always_comb begin
    head_nxt = head;
    if (pop) begin
      if (fifo_level != LEVEL_WIDTH'(1)) head_nxt = mem[rd_ptr_inc];
      else if (push_acc)                 head_nxt = push_frame;
    end else if (!out_valid && push_acc) begin
      head_nxt = push_frame;
    end
  end

  always_ff @(posedge clock) begin
    if (push_acc) mem[wr_ptr] <= push_frame;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
      head        <= '0;
    end else begin
      head <= head_nxt;
      if (push_acc) begin
        wr_ptr      <= wr_ptr + 1'b1;
        frame_count <= frame_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr_inc;
      if (push_acc && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!push_acc && pop) fifo_level <= fifo_level - 1'b1;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_codec_adc_receiver.sv
// Drives I2S channels at BCLK = clock/16 and checks popped frames against a
// record-level model of which LR periods should yield a stereo frame.
module tb_codec_adc_receiver;
  localparam int DW = 16, DEPTH = 4, LW = 3;

  logic clock = 0, reset = 0, enable = 0;
  logic aud_bclk = 0, aud_adclrck = 0, aud_adcdat = 0;
  logic out_ready = 0, clear_overflow = 0;
  logic [DW-1:0] out_left, out_right;
  logic out_valid, overflow;
  logic [LW-1:0] fifo_level;
  logic [15:0] frame_count;

  codec_adc_receiver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEVEL_WIDTH(LW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow),
    .clear_overflow(clear_overflow), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct {bit lr; logic [15:0] w; int nslots; bit en;} chan_t;
  chan_t recs[$];
  logic [31:0] exp_q[$], got_q[$], keep[$];
  int n_vec = 0, n_err = 0, exp_fc = 0;
  bit rnd_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // pop monitor, sampled well away from the rising edge
  initial forever begin
    @(negedge clock); #2;
    if (reset && out_valid && out_ready) got_q.push_back({out_left, out_right});
  end

  initial forever begin
    @(negedge clock);
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_slot(input bit lr, input bit d, input bit pulse);
    aud_bclk = 0; aud_adclrck = lr; aud_adcdat = d;
    repeat (8) @(negedge clock);
    aud_bclk = 1;
    if (pulse) begin
      repeat (3) @(negedge clock);
      out_ready = 1;
      @(negedge clock);
      out_ready = 0;
      repeat (4) @(negedge clock);
    end else repeat (8) @(negedge clock);
  endtask

  // slot 0 carries the I2S delay bit, slots 1..DW the word MSB first
  task automatic send_chan(input bit lr, input logic [15:0] w, input int nslots,
                           input int en_off, input int en_on, input bit pulse);
    bit en_ok = 1;
    bit d;
    for (int k = 0; k < nslots; k++) begin
      if (k == en_off) enable = 0;
      if (k == en_on)  enable = 1;
      if (k <= DW && !enable) en_ok = 0;
      d = (k >= 1 && k <= DW) ? w[DW-k] : 1'($urandom_range(0, 1));
      send_slot(lr, d, pulse && k == DW);
    end
    recs.push_back('{lr, w, nslots, en_ok});
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit pulse);
    send_chan(0, l, 32, -1, -1, 0);
    send_chan(1, r, 32, -1, -1, pulse);
  endtask

  function automatic bit full_word(input int k);
    return recs[k].nslots >= DW + 1 && recs[k].en;
  endfunction

  // a frame is a complete left period entered from right, followed by a complete right
  task automatic build_exp(input int from);
    exp_q.delete();
    for (int i = 1; i + 1 < recs.size(); i++)
      if (i + 1 >= from && recs[i].lr == 0 && recs[i-1].lr == 1 && recs[i+1].lr == 1 &&
          full_word(i) && full_word(i+1))
        exp_q.push_back({recs[i].w, recs[i+1].w});
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_nframes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_frame%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
  endtask

  initial begin
    int from, from2;
    int nl, nr;
    @(negedge clock);
    repeat (3) @(negedge clock);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_left", 32'(out_left), 0);
    chk("rst_right", 32'(out_right), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_fc", 32'(frame_count), 0);
    reset = 1; enable = 1; out_ready = 1;
    repeat (4) @(negedge clock);

    from = recs.size();
    send_chan(1, 16'h0, 32, -1, -1, 0);
    send_frame(16'hA5C3, 16'h1234, 0);
    repeat (20) @(negedge clock);
    build_exp(from); exp_fc += exp_q.size();
    cmp_frames("basic");
    chk("basic_fc", 32'(frame_count), 1);

    from = recs.size();
    send_chan(0, 16'($urandom), 11, -1, -1, 0);
    send_chan(1, 16'($urandom), 32, -1, -1, 0);
    send_frame(16'h7FFF, 16'h8000, 0);
    repeat (20) @(negedge clock);
    build_exp(from); exp_fc += exp_q.size();
    cmp_frames("short");
    chk("short_fc", 32'(frame_count), 32'(exp_fc));

    from = recs.size();
    send_chan(0, 16'($urandom), 32, 5, -1, 0);
    send_chan(1, 16'($urandom), 32, -1, 10, 0);
    send_frame(16'h5555, 16'hAAAA, 0);
    repeat (20) @(negedge clock);
    build_exp(from); exp_fc += exp_q.size();
    cmp_frames("enable");
    chk("enable_fc", 32'(frame_count), 32'(exp_fc));

    out_ready = 0;
    from = recs.size();
    for (int i = 0; i < 6; i++) send_frame(16'($urandom), 16'($urandom), 0);
    build_exp(from);
    chk("ovf_flag", 32'(overflow), 32'(exp_q.size() > DEPTH));
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    exp_fc += exp_q.size();
    chk("ovf_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("ovf_fc", 32'(frame_count), 32'(exp_fc));
    keep = exp_q;
    clear_overflow = 1; @(negedge clock); clear_overflow = 0; @(negedge clock);
    chk("ovf_clear", 32'(overflow), 0);

    from2 = recs.size();
    send_frame(16'($urandom), 16'($urandom), 1);
    build_exp(from2); exp_fc += exp_q.size();
    chk("bp_level", 32'(fifo_level), DEPTH);
    chk("bp_ovf", 32'(overflow), 0);
    chk("bp_fc", 32'(frame_count), 32'(exp_fc));
    for (int i = keep.size() - 1; i >= 0; i--) exp_q.push_front(keep[i]);
    out_ready = 1;
    repeat (20) @(negedge clock);
    cmp_frames("ovf_bp");

    out_ready = 0;
    from = recs.size();
    send_frame(16'($urandom), 16'($urandom), 0);
    send_frame(16'($urandom), 16'($urandom), 0);
    build_exp(from);
    chk("pre_rst_level", 32'(fifo_level), 32'(exp_q.size()));
    fork
      send_frame(16'($urandom), 16'($urandom), 0);
      begin
        repeat (100) @(negedge clock);
        #3 reset = 0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_left", 32'(out_left), 0);
        chk("arst_right", 32'(out_right), 0);
        chk("arst_level", 32'(fifo_level), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_fc", 32'(frame_count), 0);
        @(negedge clock);
        reset = 1;
      end
    join
    recs.delete(); got_q.delete(); exp_fc = 0;
    chk("post_rst_fc", 32'(frame_count), 0);
    out_ready = 1;

    from = recs.size();
    send_chan(1, 16'($urandom), 15, -1, -1, 0);
    for (int i = 1; i <= 3; i++) send_frame(16'(i), 16'(16'h8000 + i), 0);
    repeat (20) @(negedge clock);
    build_exp(from); exp_fc += exp_q.size();
    cmp_frames("startup");
    chk("startup_fc", 32'(frame_count), 3);

    rnd_rdy = 1;
    from = recs.size();
    for (int i = 0; i < 10; i++) begin
      nl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 16)) : 32;
      nr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 16)) : 32;
      send_chan(0, 16'($urandom), nl, -1, -1, 0);
      send_chan(1, 16'($urandom), nr, -1, -1, 0);
    end
    rnd_rdy = 0;
    @(negedge clock);
    out_ready = 1;
    repeat (30) @(negedge clock);
    build_exp(from); exp_fc += exp_q.size();
    cmp_frames("random");
    chk("random_fc", 32'(frame_count), 32'(exp_fc));
    chk("random_level", 32'(fifo_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
